// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns a debounced active-low key level into single, double
// and long-press pulses, and keeps a 4-bit event counter for board LEDs.
module key_event_decoder #(
  parameter int unsigned LONG_CNT = 200,
  parameter int unsigned GAP_CNT  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic [3:0] led,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_LONG_HOLD = 3'd2,
    S_WAIT_GAP  = 3'd3,
    S_PRESS2    = 3'd4
  } state_t;

  localparam logic [15:0] LONG_LAST = 16'(LONG_CNT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CNT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        key_q, key_d;
  logic        single_q, single_d;
  logic        double_q, double_d;
  logic        long_q, long_d;
  logic [3:0]  led_q, led_d;
  logic        busy_q, busy_d;
  logic        pressed_s;

  // Next-state, counter, pulse and LED-counter logic
  always_comb begin
    key_d     = key_n;
    pressed_s = ~key_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pressed_s) begin
          state_d = S_PRESS1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS1: begin
        if (!pressed_s) begin
          state_d = S_WAIT_GAP;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LONG_HOLD: begin
        if (!pressed_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LONG_HOLD;
        end
      end
      S_WAIT_GAP: begin
        // A press seen on the timeout cycle still counts as the second press
        if (pressed_s) begin
          state_d = S_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PRESS2: begin
        if (!pressed_s) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_PRESS2;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end

    if (long_d) begin
      led_d = 4'd0;
    end else if (single_d) begin
      led_d = led_q + 4'd1;
    end else if (double_d) begin
      led_d = led_q - 4'd1;
    end else begin
      led_d = led_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= 1'b1;
      cnt_q    <= 16'd0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      led_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign led          = led_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: key activity is planned as press/release
// segment pairs, a segment-level model predicts each pulse's edge, kind and LED value.
module tb_key_event_decoder;

  localparam int LONG_CNT = 200;
  localparam int GAP_CNT  = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       single_click;
  logic       double_click;
  logic       long_press;
  logic [3:0] led;
  logic       busy;

  key_event_decoder #(.LONG_CNT(LONG_CNT), .GAP_CNT(GAP_CNT)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .single_click(single_click), .double_click(double_click), .long_press(long_press),
    .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_n;
    int         kind;   // 0 single, 1 double, 2 long
    logic [3:0] led;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] m_led       = 4'd0;
  bit         m_pend      = 1'b0;  // next press falls inside the double-click gap

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input int e, input int k);
    exp_t x;
    case (k)
      0:       m_led = m_led + 4'd1;
      1:       m_led = m_led - 4'd1;
      default: m_led = 4'd0;
    endcase
    x.edge_n = e;
    x.kind   = k;
    x.led    = m_led;
    exp_q.push_back(x);
  endtask

  // a = edge that first samples the press, p = press edges, r = release edges after it
  task automatic plan_pair(input int a, input int p, input int r);
    if (m_pend) begin
      push_exp(a + p + 1, 1);
      m_pend = 1'b0;
    end else if (p >= LONG_CNT + 1) begin
      push_exp(a + LONG_CNT + 1, 2);
    end else if (r > GAP_CNT) begin
      push_exp(a + p + GAP_CNT + 1, 0);
    end else begin
      m_pend = 1'b1;
    end
  endtask

  task automatic drive_pair(input int p, input int r);
    plan_pair(edge_cnt + 1, p, r);
    key_n = 1'b0;
    repeat (p) @(negedge clk);
    key_n = 1'b1;
    repeat (r) @(negedge clk);
  endtask

  task automatic apply_reset(input int n, input logic lvl);
    rst   = 1'b1;
    key_n = lvl;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_led  = 4'd0;
    m_pend = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (single_click || double_click || long_press) begin
          if ((int'(single_click) + int'(double_click) + int'(long_press)) != 1) begin
            check("pulse_overlap", int'(single_click) + int'(double_click) + int'(long_press), 1);
          end else if (exp_q.size() == 0) begin
            check("unexpected_pulse_kind", long_press ? 2 : (double_click ? 1 : 0), -1);
          end else begin
            exp_t e;
            int   k;
            e = exp_q.pop_front();
            k = long_press ? 2 : (double_click ? 1 : 0);
            check("pulse_kind", k, e.kind);
            check("pulse_edge", edge_cnt, e.edge_n);
            check("pulse_led", int'(led), int'(e.led));
            check("pulse_busy", int'(busy), (e.kind == 2) ? 1 : 0);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_single", int'(single_click), 0);
    check("rst_double", int'(double_click), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // short press -> single click
    drive_pair(20, GAP_CNT + 5);
    check("single_led", int'(led), 1);
    check("single_busy", int'(busy), 0);

    // double click from led=0
    apply_reset(2, 1'b1);
    drive_pair(20, 10);
    drive_pair(20, 5);
    check("double_led", int'(led), 15);

    // long press from led=5
    apply_reset(2, 1'b1);
    repeat (5) drive_pair(8, GAP_CNT + 2);
    check("pre_long_led", int'(led), 5);
    drive_pair(300, 10);
    check("long_led", int'(led), 0);

    // boundary lengths: press LONG_CNT is short, gap GAP_CNT still pairs, GAP_CNT+1 does not
    drive_pair(LONG_CNT, GAP_CNT);
    drive_pair(3, GAP_CNT + 1);
    drive_pair(LONG_CNT, GAP_CNT + 1);
    drive_pair(LONG_CNT + 1, 2);
    drive_pair(1, 1);
    drive_pair(1, GAP_CNT + 1);
    drive_pair(1, GAP_CNT + 1);

    // sixteen singles wrap the counter
    apply_reset(2, 1'b1);
    repeat (16) drive_pair(5, GAP_CNT + 3);
    check("wrap_led", int'(led), 0);

    // reset in the middle of the gap, key held low through reset release
    key_n = 1'b0;
    repeat (20) @(negedge clk);
    key_n = 1'b1;
    repeat (32) @(negedge clk);
    apply_reset(2, 1'b0);
    check("midgap_rst_led", int'(led), 0);
    check("midgap_rst_busy", int'(busy), 0);
    drive_pair(LONG_CNT + 20, 5);
    check("held_long_led", int'(led), 0);

    // randomized press/release pairs
    for (int i = 0; i < 40; i++) begin
      int p;
      int r;
      if ($urandom_range(0, 3) == 0) p = $urandom_range(LONG_CNT - 5, LONG_CNT + 30);
      else                           p = $urandom_range(1, 40);
      r = $urandom_range(1, GAP_CNT + 10);
      drive_pair(p, r);
    end
    drive_pair(5, GAP_CNT + 10);

    for (int i = 0; i < 2 * (LONG_CNT + GAP_CNT) && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    check("final_led", int'(led), int'(m_led));
    check("final_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
